// File: rtl/motor_sched_pkg.sv
// Shared types and constants for the motor start-up sequencer.
package motor_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        XS0,
        XS1,
        XS2,
        YW,
        PASS,
        FAIL
    } state_t;

    localparam int STATS_W = 8;
    localparam logic [STATS_W-1:0] SAT_MAX = '1;

    function automatic logic isSearch(input state_t s);
        return (s == XS0) || (s == XS1) || (s == XS2);
    endfunction

endpackage

// File: rtl/motor_start_scheduler_rr_arbiter.sv
// Combinational rotating-priority arbiter: first eligible channel at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_CH = 4,
    localparam int GW = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] elig,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   gnt_id,
    output logic            gnt_vld
);

    int          w_sum;
    logic [GW-1:0] w_idx;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        w_sum   = 0;
        w_idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_sum = int'(ptr) + k;
            if (w_sum >= N_CH) begin
                w_sum = w_sum - N_CH;
            end
            w_idx = GW'(w_sum);
            if (!gnt_vld && elig[w_idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = w_idx;
            end
        end
    end

endmodule

// File: rtl/motor_start_scheduler.sv
// Start-up sequencer sharing one x/y sensor pair among N_CH motors.
// Define SCHED_STATS_EN to build saturating pass/fail counters; otherwise they read 0.
module motor_start_scheduler
    import motor_sched_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int X_TIMEOUT = 16,
    parameter int Y_WINDOW  = 2,
    localparam int GW = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CH-1:0]    req,
    input  logic [N_CH-1:0]    clr_fault,
    input  logic               x,
    input  logic               y,
    output logic [N_CH-1:0]    f,
    output logic [N_CH-1:0]    g,
    output logic [N_CH-1:0]    fault,
    output logic               busy,
    output logic [GW-1:0]      grant_id,
    output logic [STATS_W-1:0] pass_cnt,
    output logic [STATS_W-1:0] fail_cnt
);

    localparam int TW = $clog2(X_TIMEOUT + 1);
    localparam int WW = $clog2(Y_WINDOW + 1);
    localparam logic [TW-1:0] T_LAST = TW'(X_TIMEOUT - 1);
    localparam logic [WW-1:0] W_LAST = WW'(Y_WINDOW - 1);
    localparam logic [GW-1:0] G_LAST = GW'(N_CH - 1);

    state_t          r_state, w_nextState;
    logic [GW-1:0]   r_grant, r_ptr, w_gntId, w_grantInc;
    logic            w_gntVld, w_inSeq, w_abort, w_exit;
    logic [N_CH-1:0] r_g, r_fault, w_elig, w_grantOh;
    logic [TW-1:0]   r_timer;
    logic [WW-1:0]   r_wcnt;

    assign w_elig     = req & ~r_g & ~r_fault;
    assign w_grantOh  = N_CH'(1) << r_grant;
    assign w_grantInc = (r_grant == G_LAST) ? '0 : r_grant + GW'(1);
    assign w_inSeq    = isSearch(r_state) || (r_state == START) || (r_state == YW);
    assign w_abort    = w_inSeq && !req[r_grant];
    assign w_exit     = w_abort || (r_state == PASS) || (r_state == FAIL);

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .elig    (w_elig),
        .ptr     (r_ptr),
        .gnt_id  (w_gntId),
        .gnt_vld (w_gntVld)
    );

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_gntVld) w_nextState = START;
            START:   w_nextState = XS0;
            XS0:     w_nextState = x ? XS1 : XS0;
            XS1:     w_nextState = x ? XS1 : XS2;
            XS2:     w_nextState = x ? YW : XS0;
            YW: begin
                if (y)                    w_nextState = PASS;
                else if (r_wcnt == W_LAST) w_nextState = FAIL;
            end
            PASS:    w_nextState = IDLE;
            FAIL:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        // Reaching YW on the last search cycle still counts as success.
        if (isSearch(r_state) && r_timer == T_LAST && w_nextState != YW) begin
            w_nextState = FAIL;
        end
        if (w_abort) begin
            w_nextState = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_timer <= '0;
            r_wcnt  <= '0;
            r_g     <= '0;
            r_fault <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_gntVld) begin
                r_grant <= w_gntId;
            end
            if (r_state == START) begin
                r_timer <= '0;
            end else if (isSearch(r_state)) begin
                r_timer <= r_timer + TW'(1);
            end
            if (r_state != YW) begin
                r_wcnt <= '0;
            end else begin
                r_wcnt <= r_wcnt + WW'(1);
            end
            if (w_exit) begin
                r_ptr <= w_grantInc;
            end
            r_g     <= (r_g & req) | ((r_state == PASS) ? w_grantOh : '0);
            r_fault <= (r_fault & ~clr_fault) | ((r_state == FAIL) ? w_grantOh : '0);
        end
    end

    assign f        = (r_state == START) ? w_grantOh : '0;
    assign g        = r_g;
    assign fault    = r_fault;
    assign busy     = (r_state != IDLE);
    assign grant_id = (r_state != IDLE) ? r_grant : '0;

`ifdef SCHED_STATS_EN
    logic [STATS_W-1:0] r_passCnt, r_failCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_passCnt <= '0;
            r_failCnt <= '0;
        end else begin
            if (r_state == PASS && r_passCnt != SAT_MAX) begin
                r_passCnt <= r_passCnt + STATS_W'(1);
            end
            if (r_state == FAIL && r_failCnt != SAT_MAX) begin
                r_failCnt <= r_failCnt + STATS_W'(1);
            end
        end
    end

    assign pass_cnt = r_passCnt;
    assign fail_cnt = r_failCnt;
`else
    assign pass_cnt = '0;
    assign fail_cnt = '0;
`endif

endmodule
